// File: rtl/i2c_mbus_byte_master.sv
// i2c_mbus_byte_master: command-driven I2C byte engine over NUM_BUSES selectable buses
module i2c_mbus_byte_master #(
  parameter int NUM_BUSES = 16,
  parameter int DIV_W = 16,
  localparam int BID_W = NUM_BUSES > 1 ? $clog2(NUM_BUSES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_code_i,
  input  logic [7:0]           cmd_data_i,
  output logic                 rsp_valid_o,
  output logic [2:0]           rsp_code_o,
  output logic [7:0]           rsp_data_o,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [NUM_BUSES-1:0] scl_i,
  input  logic [NUM_BUSES-1:0] sda_i,
  output logic [NUM_BUSES-1:0] scl_oe_o,
  output logic [NUM_BUSES-1:0] sda_oe_o,
  output logic [BID_W-1:0]     bus_id_o,
  output logic                 bus_taken_o
);
  typedef enum logic [3:0] {
    S_IDLE, S_TAKEN, S_START, S_STOP, S_WBIT, S_WACK, S_RBIT, S_RACK, S_WAIT, S_RESP
  } state_t;
  localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2, C_RACK = 3'd3,
                         C_RNAK = 3'd4, C_SETBUS = 3'd5, C_WAIT = 3'd6;
  localparam logic [2:0] R_DONE = 3'd0, R_ACK = 3'd1, R_NAK = 3'd2, R_BYTE = 3'd3,
                         R_ARB = 3'd4, R_ERR = 3'd5;
  state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [2:0] bit_q, bit_d, code_q, code_d, rcode_q, rcode_d;
  logic [7:0] sh_q, sh_d, rdata_q, rdata_d;
  logic taken_q, taken_d;
  logic [BID_W-1:0] bus_q, bus_d;
  logic scl_drv, sda_drv, scl_in, sda_in, active, hold, tick, in_range;
  assign div_eff = (div_i == '0) ? DIV_W'(1) : div_i;
  assign in_range = {24'd0, cmd_data_i} < 32'(NUM_BUSES);
  assign scl_in = scl_i[bus_q];
  assign sda_in = sda_i[bus_q];
  assign active = state_q inside {S_START, S_STOP, S_WBIT, S_WACK, S_RBIT, S_RACK, S_WAIT};
  assign hold = !scl_drv && !scl_in;
  assign tick = active && !hold && cnt_q == DIV_W'(1);
  assign cmd_ready_o = rst_n_i && (state_q == S_IDLE || state_q == S_TAKEN);
  assign rsp_valid_o = state_q == S_RESP;
  assign rsp_code_o = rsp_valid_o ? rcode_q : '0;
  assign rsp_data_o = rsp_valid_o ? rdata_q : '0;
  assign scl_oe_o = NUM_BUSES'(scl_drv) << bus_q;
  assign sda_oe_o = NUM_BUSES'(sda_drv) << bus_q;
  assign bus_id_o = bus_q;
  assign bus_taken_o = taken_q;
  // line drive per state/phase; outside a transfer SCL stays low only while we own the bus
  always_comb begin
    scl_drv = taken_q;
    sda_drv = 1'b0;
    case (state_q)
      S_START: begin
        scl_drv = (phase_q == 2'd0) ? taken_q : phase_q == 2'd3;
        sda_drv = phase_q[1];
      end
      S_STOP: begin
        scl_drv = phase_q == 2'd0 && taken_q;
        sda_drv = !phase_q[1];
      end
      S_WBIT, S_WACK, S_RBIT, S_RACK: begin
        scl_drv = phase_q[0] == phase_q[1];
        sda_drv = (state_q == S_WBIT) ? !sh_q[7] : (state_q == S_RACK) && code_q == C_RACK;
      end
      default: ;
    endcase
  end
  // command decode, quarter-bit sequencing and response generation
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d = cnt_q;
    div_d = div_q;
    bit_d = bit_q;
    sh_d = sh_q;
    code_d = code_q;
    rcode_d = rcode_q;
    rdata_d = rdata_q;
    taken_d = taken_q;
    bus_d = bus_q;
    if (active && !hold) cnt_d = tick ? div_q : cnt_q - DIV_W'(1);
    if (tick) phase_d = phase_q + 2'd1;
    case (state_q)
      S_IDLE, S_TAKEN: if (cmd_valid_i) begin
        code_d = cmd_code_i;
        sh_d = cmd_data_i;
        bit_d = '0;
        phase_d = '0;
        cnt_d = div_eff;
        div_d = div_eff;
        rdata_d = '0;
        rcode_d = R_ERR;
        state_d = S_RESP;
        case (cmd_code_i)
          C_START: state_d = S_START;
          C_STOP: state_d = S_STOP;
          C_WRITE: state_d = taken_q ? S_WBIT : S_RESP;
          C_RACK, C_RNAK: state_d = taken_q ? S_RBIT : S_RESP;
          C_SETBUS: if (!taken_q && in_range) begin
            bus_d = cmd_data_i[BID_W-1:0];
            rcode_d = R_DONE;
          end
          C_WAIT: begin
            state_d = (cmd_data_i == 8'd0) ? S_RESP : S_WAIT;
            rcode_d = R_DONE;
          end
          default: ;
        endcase
      end
      S_START: if (tick && phase_q == 2'd3) begin
        state_d = S_RESP;
        rcode_d = R_DONE;
        taken_d = 1'b1;
      end
      S_STOP: if (tick && phase_q == 2'd3) begin
        state_d = S_RESP;
        rcode_d = R_DONE;
        taken_d = 1'b0;
      end
      S_WBIT: if (tick && phase_q == 2'd1 && sh_q[7] && !sda_in) begin
        state_d = S_RESP;
        rcode_d = R_ARB;
        taken_d = 1'b0;
      end else if (tick && phase_q == 2'd3) begin
        sh_d = {sh_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_WACK;
      end
      S_WACK: if (tick && phase_q == 2'd1) sh_d = {sh_q[7:1], sda_in};
        else if (tick && phase_q == 2'd3) begin
        state_d = S_RESP;
        rcode_d = sh_q[0] ? R_NAK : R_ACK;
      end
      S_RBIT: if (tick && phase_q == 2'd1) sh_d = {sh_q[6:0], sda_in};
        else if (tick && phase_q == 2'd3) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_RACK;
      end
      S_RACK: if (tick && phase_q == 2'd3) begin
        state_d = S_RESP;
        rcode_d = R_BYTE;
        rdata_d = sh_q;
      end
      S_WAIT: if (tick && phase_q == 2'd3) begin
        sh_d = sh_q - 8'd1;
        if (sh_q == 8'd1) state_d = S_RESP;
      end
      S_RESP: state_d = taken_q ? S_TAKEN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cnt_q <= DIV_W'(1);
      div_q <= DIV_W'(1);
      bit_q <= '0;
      sh_q <= '0;
      code_q <= '0;
      rcode_q <= '0;
      rdata_q <= '0;
      taken_q <= 1'b0;
      bus_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      code_q <= code_d;
      rcode_q <= rcode_d;
      rdata_q <= rdata_d;
      taken_q <= taken_d;
      bus_q <= bus_d;
    end
  end
endmodule

// File: tb/tb_i2c_mbus_byte_master.sv
// tb_i2c_mbus_byte_master: directed test of the I2C byte engine with a simple slave on bus 3
module tb_i2c_mbus_byte_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic [2:0] cmd_code = '0;
  logic [7:0] cmd_data = '0;
  logic [15:0] div = 16'd4;
  logic cmd_ready, rsp_valid, bus_taken;
  logic [2:0] rsp_code;
  logic [7:0] rsp_data;
  logic [15:0] scl_in, sda_in, scl_oe, sda_oe;
  logic [3:0] bus_id;
  logic stretch = 1'b0, slave_pull = 1'b0, ext_pull = 1'b0, stretch_en = 1'b0, other_bus = 1'b0;
  logic prev_scl = 1'b0;
  int slave_mode = 0;
  logic [7:0] slave_byte = '0;
  logic [15:0] hist = '0;
  int cyc = 0, rel_t = 0, rel_period = 0, rel_cnt = 0, stretch_left = 0;
  int tests = 0, fails = 0;
  logic [2:0] rc;
  logic [7:0] rd;
  int lat, n;

  assign scl_in = ~scl_oe & ~({15'd0, stretch} << 3);
  assign sda_in = ~sda_oe & ~({15'd0, slave_pull | ext_pull} << 3);

  i2c_mbus_byte_master dut (
    .clk_i(clk), .rst_n_i(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_code_i(cmd_code), .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid),
    .rsp_code_o(rsp_code), .rsp_data_o(rsp_data), .div_i(div), .scl_i(scl_in),
    .sda_i(sda_in), .scl_oe_o(scl_oe), .sda_oe_o(sda_oe), .bus_id_o(bus_id),
    .bus_taken_o(bus_taken)
  );

  always #5 clk = ~clk;

  // slave on bus 3: ACKs writes, serves slave_byte on reads, optional SCL stretch
  always @(negedge clk) begin
    cyc++;
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) stretch = 1'b0;
    end
    if (slave_mode == 0) slave_pull = 1'b0;
    if (((scl_oe | sda_oe) & 16'hFFF7) != 16'd0) other_bus = 1'b1;
    if (prev_scl && !scl_oe[3]) begin
      hist = {hist[14:0], ~sda_oe[3]};
      rel_period = cyc - rel_t;
      rel_t = cyc;
      if (slave_mode == 1 && rel_cnt == 8) slave_pull = 1'b1;
      if (slave_mode == 2 && rel_cnt < 8) slave_pull = !slave_byte[7 - rel_cnt];
      if (stretch_en && rel_cnt == 2) begin
        stretch = 1'b1;
        stretch_left = 50;
      end
      rel_cnt++;
    end
    if (!prev_scl && scl_oe[3]) slave_pull = 1'b0;
    prev_scl = scl_oe[3];
    if (cmd_valid && cmd_ready) rel_cnt = 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one command; lat = negedges from acceptance edge to the response strobe
  task automatic send(input logic [2:0] code, input logic [7:0] data,
                      output logic [2:0] c, output logic [7:0] d, output int l);
    int w;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_code = code;
    cmd_data = data;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    c = 3'd7;
    d = 8'hEE;
    l = 0;
    while (l < 3000) begin
      @(negedge clk);
      l++;
      if (rsp_valid) begin
        c = rsp_code;
        d = rsp_data;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);
    check("oe_after_reset", 32'({scl_oe, sda_oe}), 32'd0);
    check("bus_id_reset", 32'(bus_id), 32'd0);
    check("taken_reset", 32'(bus_taken), 32'd0);
    check("rsp_valid_reset", 32'(rsp_valid), 32'd0);

    send(3'd5, 8'd3, rc, rd, lat);
    check("setbus3_rsp", 32'(rc), 32'd0);
    check("setbus3_id", 32'(bus_id), 32'd3);

    slave_mode = 1;
    send(3'd0, 8'd0, rc, rd, lat);
    check("start_rsp", 32'(rc), 32'd0);
    check("start_taken", 32'(bus_taken), 32'd1);
    send(3'd2, 8'h5A, rc, rd, lat);
    check("write5a_rsp", 32'(rc), 32'd1);
    check("write5a_sda_seq", 32'(hist[8:0]), 32'h0B5);
    check("bit_period", 32'(rel_period), 32'd16);
    @(negedge clk);
    check("ready_after_rsp", 32'(cmd_ready), 32'd1);
    send(3'd1, 8'd0, rc, rd, lat);
    check("stop_rsp", 32'(rc), 32'd0);
    check("stop_taken", 32'(bus_taken), 32'd0);
    check("stop_lines", 32'({scl_oe, sda_oe}), 32'd0);

    send(3'd0, 8'd0, rc, rd, lat);
    slave_mode = 2;
    slave_byte = 8'hC3;
    send(3'd4, 8'd0, rc, rd, lat);
    check("readnak_rsp", 32'(rc), 32'd3);
    check("readnak_data", 32'(rd), 32'hC3);
    check("readnak_9th_released", 32'(hist[0]), 32'd1);
    slave_mode = 0;
    send(3'd1, 8'd0, rc, rd, lat);

    send(3'd0, 8'd0, rc, rd, lat);
    slave_mode = 1;
    send(3'd2, 8'hFF, rc, rd, lat);
    check("writeff_rsp", 32'(rc), 32'd1);
    check("writeff_lat", 32'(lat), 32'd145);
    stretch_en = 1'b1;
    send(3'd2, 8'hFF, rc, rd, lat);
    stretch_en = 1'b0;
    check("stretch_rsp", 32'(rc), 32'd1);
    check("stretch_lat", 32'(lat), 32'd195);
    slave_mode = 0;
    send(3'd1, 8'd0, rc, rd, lat);

    send(3'd0, 8'd0, rc, rd, lat);
    ext_pull = 1'b1;
    send(3'd2, 8'h80, rc, rd, lat);
    check("arb_rsp", 32'(rc), 32'd4);
    check("arb_lat", 32'(lat), 32'd9);
    check("arb_lines", 32'({scl_oe, sda_oe}), 32'd0);
    check("arb_taken", 32'(bus_taken), 32'd0);
    ext_pull = 1'b0;

    send(3'd2, 8'h11, rc, rd, lat);
    check("write_untaken_rsp", 32'(rc), 32'd5);
    check("write_untaken_lat", 32'(lat), 32'd1);
    send(3'd5, 8'd16, rc, rd, lat);
    check("setbus16_rsp", 32'(rc), 32'd5);
    check("setbus16_id", 32'(bus_id), 32'd3);
    send(3'd6, 8'd0, rc, rd, lat);
    check("wait0_rsp", 32'(rc), 32'd0);
    check("wait0_lat", 32'(lat), 32'd1);
    send(3'd6, 8'd3, rc, rd, lat);
    check("wait3_rsp", 32'(rc), 32'd0);
    check("wait3_lat", 32'(lat), 32'd49);
    div = 16'd0;
    send(3'd6, 8'd2, rc, rd, lat);
    check("wait2_div0_lat", 32'(lat), 32'd9);
    div = 16'd4;
    send(3'd7, 8'd0, rc, rd, lat);
    check("reserved_rsp", 32'(rc), 32'd5);
    send(3'd0, 8'd0, rc, rd, lat);
    send(3'd5, 8'd2, rc, rd, lat);
    check("setbus_taken_rsp", 32'(rc), 32'd5);
    check("setbus_taken_id", 32'(bus_id), 32'd3);
    check("other_bus_quiet", 32'(other_bus), 32'd0);

    slave_mode = 2;
    slave_byte = 8'h0F;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_code = 3'd3;
    cmd_data = 8'd0;
    @(negedge clk);
    check("read_accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    slave_mode = 0;
    check("abort_lines", 32'({scl_oe, sda_oe}), 32'd0);
    check("abort_taken", 32'(bus_taken), 32'd0);
    check("abort_bus_id", 32'(bus_id), 32'd0);
    rst_n = 1'b1;
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    check("abort_no_rsp", 32'(n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_mbus_byte_master.md
Name: i2c_mbus_byte_master

Overview:
Parametrised, command-driven I2C master byte engine serving NUM_BUSES independent I2C buses, one bus selected at a time. It is the next-generation core behind the i2cmb register front end. The Wishbone register block pushes byte-level commands (start, stop, write, read, set-bus, wait) and receives one response per command. Over the existing controller it adds a parametrised bus count, a runtime clock divider, SCL clock-stretch support, and arbitration-loss detection.

Parameters:
NUM_BUSES, 16, number of I2C buses; bus index width BID_W = max(1, clog2(NUM_BUSES)).
DIV_W, 16, width of the quarter-bit-period divider input.

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset.
cmd_valid_i  in  1  command valid.
cmd_ready_o  out  1  engine can accept a command.
cmd_code_i  in  3  0=START, 1=STOP, 2=WRITE, 3=READ_ACK, 4=READ_NAK, 5=SET_BUS, 6=WAIT, 7=reserved.
cmd_data_i  in  8  write byte / bus id / wait count.
rsp_valid_o  out  1  one-cycle response strobe.
rsp_code_o  out  3  0=DONE, 1=ACK, 2=NAK, 3=BYTE, 4=ARB_LOST, 5=ERROR.
rsp_data_o  out  8  byte read (valid with BYTE), else 0.
div_i  in  DIV_W  clk_i cycles per quarter bit period; a value of 0 is treated as 1.
scl_i  in  NUM_BUSES  sampled SCL of each bus.
sda_i  in  NUM_BUSES  sampled SDA of each bus.
scl_oe_o  out  NUM_BUSES  1 = pull SCL low (open drain).
sda_oe_o  out  NUM_BUSES  1 = pull SDA low (open drain).
bus_id_o  out  BID_W  currently selected bus.
bus_taken_o  out  1  this master owns the selected bus (START issued, no STOP yet).

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - Reset values: all oe outputs 0, bus_id_o 0, bus_taken_o 0, rsp_valid_o 0, rsp_code_o 0, rsp_data_o 0, state IDLE, cmd_ready_o 0 during reset.
  - Asserting reset mid-operation releases all lines on the next edge. No response is produced for the aborted command.
- Only the selected bus is driven. The oe bits of non-selected buses stay 0.
- Handshake:
  - cmd_ready_o = 1 only in IDLE or TAKEN. A command is accepted on the edge where valid & ready.
  - cmd_ready_o drops the cycle after acceptance and returns high the cycle after rsp_valid_o.
  - Exactly one response per accepted command. There is no response backpressure.
- Tick: a counter reloads with max(div_i, 1) and emits a tick on reaching 1.
  - div_i is sampled at command acceptance and held for the whole command.
  - Each bit occupies 4 ticks (phases Q0..Q3).
- Clock stretch: after releasing SCL, the tick counter holds until scl_i[bus] reads 1.
- States: IDLE, TAKEN, START, STOP, WBIT, WACK, RBIT, RACK, WAIT, RESP.
- START (IDLE or TAKEN):
  - Phase sequence: SDA released and SCL released → SDA low → SCL low.
  - From TAKEN this is a repeated start.
  - Response DONE; bus_taken_o = 1.
- STOP:
  - Phase sequence: SDA low → SCL released → SDA released.
  - Response DONE; bus_taken_o = 0; next state IDLE.
  - STOP while not taken is still executed and answers DONE.
- WRITE (TAKEN only):
  - 8 bits MSB first, SDA changing only while SCL is low.
  - Then a 9th bit with SDA released; sda_i is sampled at mid SCL-high.
  - Response ACK if the sampled bit is 0, NAK if 1.
- Arbitration lost: in WRITE, if SDA is released for a 1 but sda_i reads 0 at mid SCL-high:
  - release both lines immediately;
  - respond ARB_LOST;
  - bus_taken_o = 0; return to IDLE.
- READ_ACK / READ_NAK (TAKEN only):
  - 8 bits sampled MSB first, then drive ACK (SDA low) or NAK (released).
  - Response BYTE with the byte on rsp_data_o.
- WRITE / READ while not taken: respond ERROR within 2 cycles, with no line activity.
- SET_BUS (IDLE only):
  - If cmd_data_i < NUM_BUSES: bus_id_o is updated, response DONE.
  - Otherwise respond ERROR and leave bus_id_o unchanged.
  - SET_BUS while taken: ERROR.
- WAIT: idle for cmd_data_i×4 ticks with lines unchanged, then DONE. A count of 0 gives immediate DONE.
- Reserved code 7: ERROR.
- rsp_valid_o is asserted in RESP for exactly one cycle, then the engine goes to TAKEN or IDLE per bus_taken_o.

Test Plan:
- Reset with rst_n_i=0 for 3 cycles → all oe 0, bus_id_o 0, cmd_ready_o 1 on the first cycle after release.
- SET_BUS 3, START, WRITE 0x5A (slave ACKs), STOP with div_i=4 → only bit 3 of the oe vectors toggles; SDA sequence 0,1,0,1,1,0,1,0; responses DONE, DONE, ACK, DONE; each bit lasts 16 clocks.
- START, READ_NAK with the slave driving 0xC3 → response BYTE with rsp_data_o=0xC3; SDA released in the 9th bit.
- Slave holds SCL low 50 cycles during bit 2 of WRITE 0xFF → bit timing extended by 50 cycles; response still ACK/NAK.
- External device pulls SDA low during WRITE 0x80 bit 1 → response ARB_LOST, both oe 0 the next cycle, bus_taken_o 0.
- WRITE with no START → ERROR; SET_BUS 16 with NUM_BUSES=16 → ERROR with bus_id_o unchanged; WAIT 0 → DONE within 2 cycles; rst_n_i low mid-READ → lines released, no response.
